// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: two read ports, one write port,
// and the registered status flags.
interface reg_file_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            ready;
    logic            wr_drop;

    modport master (
        output ra1, ra2, we, wa, wd,
        input  rd1, rd2, ready, wr_drop
    );

    modport slave (
        input  ra1, ra2, we, wa, wd,
        output rd1, rd2, ready, wr_drop
    );
endinterface

// File: rtl/reg_file_mp.sv
// Two-read / one-write register file with hardwired x0, a post-reset clear sweep,
// and optional write-to-read forwarding.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_mp_if.slave bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] FIRST = AW'(1);
    localparam logic [AW-1:0] LAST  = AW'(NREG - 1);

    state_t          state;
    logic [AW-1:0]   cnt;

    // NOTE: the storage array has no reset; a reset port on every entry would
    // stop it mapping to RAM, so the CLEAR sweep zeroes it instead.
    logic [XLEN-1:0] mem [1:NREG-1];

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples its inputs from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            cnt         <= FIRST;
            bus.ready   <= 1'b0;
            bus.wr_drop <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    bus.wr_drop <= bus.we;
                    if (cnt == LAST) begin
                        state     <= RUN;
                        bus.ready <= 1'b1;
                    end else begin
                        cnt <= cnt + FIRST;
                    end
                end
                RUN: begin
                    bus.wr_drop <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // During CLEAR the sweep owns the write port and user writes are discarded.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (bus.we && (bus.wa != '0)) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // NOTE: each combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        bus.rd1 = '0;
        if (bus.ready && (bus.ra1 != '0)) begin
            if ((BYPASS != 0) && bus.we && (bus.wa == bus.ra1)) begin
                bus.rd1 = bus.wd;
            end else begin
                bus.rd1 = mem[bus.ra1];
            end
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (bus.ready && (bus.ra2 != '0)) begin
            if ((BYPASS != 0) && bus.we && (bus.wa == bus.ra2)) begin
                bus.rd2 = bus.wd;
            end else begin
                bus.rd2 = mem[bus.ra2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: three instances (forwarding, no forwarding,
// and a small 8x16 configuration) share one clock and reset.
module tb_reg_file_mp;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    reg_file_mp_if #(.XLEN(32), .AW(5)) ba ();
    reg_file_mp_if #(.XLEN(32), .AW(5)) bb ();
    reg_file_mp_if #(.XLEN(16), .AW(3)) bc ();

    reg_file_mp #(.XLEN(32), .NREG(32), .BYPASS(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    reg_file_mp #(.XLEN(32), .NREG(32), .BYPASS(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(bb));
    reg_file_mp #(.XLEN(16), .NREG(8),  .BYPASS(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(bc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs edges until all three instances are ready (bounded), recording the
    // edge at which each became ready and how many drops instance A flagged.
    task automatic sweep(output int ea, output int eb, output int ec, output int da);
        ea = 0; eb = 0; ec = 0; da = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ba.wr_drop) da++;
            if (ba.ready && ea == 0) ea = n;
            if (bb.ready && eb == 0) eb = n;
            if (bc.ready && ec == 0) ec = n;
            if (n == 10) check("clear_rd1_zero", ba.rd1, 0);
            if (ea != 0 && eb != 0 && ec != 0) break;
            ba.wa = 5'((n % 31) + 1);
        end
        ba.we = 1'b0;
    endtask

    initial begin
        int ea, eb, ec, da;

        rst_n = 1'b0;
        ba.we = 1'b1; ba.wa = 5'd1; ba.wd = 32'hFFFF_FFFF; ba.ra1 = 5'd3; ba.ra2 = 5'd4;
        bb.we = 1'b0; bb.wa = '0;   bb.wd = '0;            bb.ra1 = '0;   bb.ra2 = '0;
        bc.we = 1'b0; bc.wa = '0;   bc.wd = '0;            bc.ra1 = 3'd2; bc.ra2 = '0;

        // Reset held: writes presented but nothing may respond
        repeat (3) tick();
        check("rst_ready",   ba.ready,   0);
        check("rst_wr_drop", ba.wr_drop, 0);
        check("rst_rd1",     ba.rd1,     0);
        check("rst_rd2",     ba.rd2,     0);
        check("rst_c_ready", bc.ready,   0);
        check("rst_c_rd1",   bc.rd1,     0);

        // Sweep after first release with writes every cycle
        rst_n = 1'b1;
        ba.ra1 = 5'd31;
        sweep(ea, eb, ec, da);
        check("sweep_edges_a",  ea, 31);
        check("sweep_drops_a",  da, 31);
        check("sweep_edges_b",  eb, 31);
        check("sweep_edges_c",  ec, 7);
        check("run_c_no_drop",  bc.wr_drop, 0);

        for (int i = 0; i < 32; i++) begin
            ba.ra1 = 5'(i);
            ba.ra2 = 5'(31 - i);
            #1;
            check("zero_rd1", ba.rd1, 0);
            check("zero_rd2", ba.rd2, 0);
            tick();
        end
        check("run_no_drop", ba.wr_drop, 0);

        // Write x5, forward in the same cycle, read stored value next cycle
        ba.we = 1'b1; ba.wa = 5'd5; ba.wd = 32'hDEAD_BEEF; ba.ra1 = 5'd5; ba.ra2 = 5'd6;
        #1;
        check("x5_fwd_rd1", ba.rd1, 32'hDEAD_BEEF);
        check("x6_rd2",     ba.rd2, 0);
        tick();
        ba.we = 1'b0;
        #1;
        check("x5_rd1",      ba.rd1,     32'hDEAD_BEEF);
        check("x5_wr_drop",  ba.wr_drop, 0);

        // Writes to x0 have no effect and no drop flag
        ba.we = 1'b1; ba.wa = 5'd0; ba.wd = 32'h1234_5678; ba.ra2 = 5'd0;
        #1;
        check("x0_fwd_rd2", ba.rd2, 0);
        tick();
        ba.we = 1'b0;
        #1;
        check("x0_rd2",     ba.rd2,     0);
        check("x0_wr_drop", ba.wr_drop, 0);
        check("x5_kept",    ba.rd1,     32'hDEAD_BEEF);

        // Forwarding vs stored-only on a same-cycle write to x7
        ba.we = 1'b1; ba.wa = 5'd7; ba.wd = 32'h1;
        bb.we = 1'b1; bb.wa = 5'd7; bb.wd = 32'h1;
        tick();
        ba.wd = 32'h2; bb.wd = 32'h2;
        ba.ra1 = 5'd7; ba.ra2 = 5'd7; bb.ra1 = 5'd7; bb.ra2 = 5'd7;
        #1;
        check("byp1_rd1", ba.rd1, 32'h2);
        check("byp1_rd2", ba.rd2, 32'h2);
        check("byp0_rd1", bb.rd1, 32'h1);
        check("byp0_rd2", bb.rd2, 32'h1);
        tick();
        ba.we = 1'b0; bb.we = 1'b0;
        #1;
        check("byp0_after_rd1", bb.rd1, 32'h2);
        check("byp0_after_rd2", bb.rd2, 32'h2);
        check("byp1_after_rd1", ba.rd1, 32'h2);

        // Ports are independent: one forwards, the other reads storage
        ba.we = 1'b1; ba.wa = 5'd5; ba.wd = 32'hCAFE_F00D; ba.ra1 = 5'd5; ba.ra2 = 5'd7;
        #1;
        check("indep_rd1", ba.rd1, 32'hCAFE_F00D);
        check("indep_rd2", ba.rd2, 32'h2);
        tick();
        ba.we = 1'b0;

        // Fill x1..x31, then reset mid-program
        for (int i = 1; i < 32; i++) begin
            ba.we = 1'b1; ba.wa = 5'(i); ba.wd = 32'(i) * 32'h0101_0101;
            tick();
        end
        ba.we = 1'b0; ba.ra1 = 5'd3; ba.ra2 = 5'd31;
        #1;
        check("fill_x3",  ba.rd1, 32'h0303_0303);
        check("fill_x31", ba.rd2, 32'h1F1F_1F1F);

        rst_n = 1'b0;
        #1;
        check("abort_ready", ba.ready, 0);
        check("abort_rd1",   ba.rd1,   0);
        check("abort_rd2",   ba.rd2,   0);
        check("abort_c_rdy", bc.ready, 0);
        ba.we = 1'b1; ba.wa = 5'd1; ba.wd = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("abort_hold_drop", ba.wr_drop, 0);
        rst_n = 1'b1;
        ba.ra1 = 5'd31;
        sweep(ea, eb, ec, da);
        check("resweep_edges_a", ea, 31);
        check("resweep_drops_a", da, 31);
        check("resweep_edges_c", ec, 7);

        for (int i = 1; i < 32; i++) begin
            ba.ra1 = 5'(i);
            #1;
            check("cleared_rd1", ba.rd1, 0);
            tick();
        end

        // Small configuration: top register round trip on both ports
        bc.we = 1'b1; bc.wa = 3'd7; bc.wd = 16'hA5A5;
        tick();
        bc.we = 1'b0; bc.ra1 = 3'd7; bc.ra2 = 3'd7;
        #1;
        check("c_x7_rd1",    bc.rd1,     16'hA5A5);
        check("c_x7_rd2",    bc.rd2,     16'hA5A5);
        check("c_x7_drop",   bc.wr_drop, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
